// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtracter:
// command codes, FSM state encoding and signed-overflow helper.
package addsub_pkg;

    localparam int unsigned CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_ADD = 3'b000;
    localparam logic [CMD_W-1:0] CMD_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of r = a + b, from the operand and result MSBs.
    function automatic logic signed_overflow(input logic a_msb,
                                             input logic b_msb,
                                             input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit ripple-carry adder built from 1-bit full adders; purely combinational.
// Ports:
//   x, y  : SLICE-bit addends
//   cin   : carry into bit 0
//   sum   : SLICE-bit sum
//   cout  : carry out of the top bit
module addsub_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[SLICE];

endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle WIDTH-bit adder/subtracter. One shared SLICE-bit adder is
// stepped over the operands, one slice per clock, under a small FSM.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand-side handshake (a, b, command)
//   out_valid/ out_ready: result-side handshake
//   result              : sum or difference (qualify with out_valid)
//   carryout            : carry out of MSB (for SUB, 1 = no borrow)
//   overflow            : signed overflow
//   zero                : result == 0
//   error               : accepted command was illegal
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CMD_W-1:0] command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             error
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    // Reject configurations the slice stepping cannot cover exactly.
    if ((SLICE < 1) || (WIDTH < 2) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $fatal(1, "addsub_multicycle: SLICE must divide WIDTH and WIDTH must be >= 2");
    end

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // b already inverted for SUB
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             in_ready_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] result_d;
    logic             carryout_d;
    logic             overflow_d;
    logic             zero_d;
    logic             error_d;

    // Slice-indexed views of the operand registers.
    logic [NSLICE-1:0][SLICE-1:0] a_s, b_s;
    logic [NSLICE-1:0][SLICE-1:0] res_s;
    logic [SLICE-1:0]             slice_sum;
    logic                         slice_cout;
    logic                         cmd_legal;
    logic                         cmd_sub;

    assign a_s = a_q;
    assign b_s = b_q;

    assign cmd_sub   = (command == CMD_SUB);
    assign cmd_legal = (command == CMD_ADD) || cmd_sub;

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .x    (a_s[idx_q]),
        .y    (b_s[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        result_d    = result;
        carryout_d  = carryout;
        overflow_d  = overflow;
        zero_d      = zero;
        error_d     = error;
        res_s       = result;

        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    in_ready_d = 1'b0;
                    if (cmd_legal) begin
                        a_d     = a;
                        b_d     = cmd_sub ? ~b : b;
                        carry_d = cmd_sub;
                        idx_d   = '0;
                        error_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        // Illegal command completes immediately with a fixed response.
                        result_d    = '0;
                        carryout_d  = 1'b0;
                        overflow_d  = 1'b0;
                        zero_d      = 1'b1;
                        error_d     = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            RUN: begin
                in_ready_d   = 1'b0;
                res_s[idx_q] = slice_sum;
                result_d     = res_s;
                carry_d      = slice_cout;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    carryout_d  = slice_cout;
                    overflow_d  = signed_overflow(a_q[WIDTH-1], b_q[WIDTH-1], result_d[WIDTH-1]);
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                in_ready_d = 1'b0;
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            error     <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            result    <= result_d;
            carryout  <= carryout_d;
            overflow  <= overflow_d;
            zero      <= zero_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_addsub_multicycle.sv
// Self-checking bench for addsub_multicycle (WIDTH=32, SLICE=8).
module tb_addsub_multicycle;

    localparam int unsigned W  = 32;
    localparam int unsigned S  = 8;
    localparam int unsigned NS = W / S;

    typedef struct packed {
        logic [W-1:0] result;
        logic         carryout;
        logic         overflow;
        logic         zero;
        logic         error;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   command;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;
    logic         error;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    addsub_multicycle #(.WIDTH(W), .SLICE(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .command   (command),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: full-width arithmetic with an explicit 33rd bit.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic [2:0] mc);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] be;
        logic         ci;
        if (mc != 3'b000 && mc != 3'b001) begin
            e = '{result: '0, carryout: 1'b0, overflow: 1'b0, zero: 1'b1, error: 1'b1};
            return e;
        end
        ci = (mc == 3'b001);
        be = ci ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, ci};
        e.result   = s[W-1:0];
        e.carryout = s[W];
        e.overflow = (ma[W-1] == be[W-1]) && (s[W-1] != ma[W-1]);
        e.zero     = (s[W-1:0] == '0);
        e.error    = 1'b0;
        return e;
    endfunction

    // Issue one request, optionally stall the result for 'hold' cycles, then retire it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [2:0] tc, input exp_t e, input int hold,
                          input string name);
        int   waitc;
        int   lat;
        int   exp_lat;
        exp_t want;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        a        = ta;
        b        = tb_;
        command  = tc;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        // Scramble operands while running; they must not matter.
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        command  = 3'($urandom_range(0, 7));
        // lat counts edges including the accepting edge.
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = (tc == 3'b000 || tc == 3'b001) ? NS + 1 : 1;
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d edges want %0d", name, lat, exp_lat);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            command  = 3'b000;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result, carryout, overflow, zero, error} !==
                {1'b1, 1'b0, e.result, e.carryout, e.overflow, e.zero, e.error}) begin
                failures++;
                $display("FAIL %s_hold%0d: got v=%b rdy=%b r=%h c=%b o=%b z=%b e=%b want r=%h c=%b o=%b z=%b e=%b",
                         name, i, out_valid, in_ready, result, carryout, overflow, zero, error,
                         e.result, e.carryout, e.overflow, e.zero, e.error);
            end
        end
        in_valid = 1'b0;
        want = sb.pop_front();
        checks++;
        if (result !== want.result) begin
            failures++;
            $display("FAIL %s_result: got %h want %h", name, result, want.result);
        end
        checks++;
        if ({carryout, overflow, zero, error} !==
            {want.carryout, want.overflow, want.zero, want.error}) begin
            failures++;
            $display("FAIL %s_flags: got c=%b o=%b z=%b e=%b want c=%b o=%b z=%b e=%b",
                     name, carryout, overflow, zero, error,
                     want.carryout, want.overflow, want.zero, want.error);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_retire: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        command   = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, carryout, overflow, zero, error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b v=%b r=%h c=%b o=%b z=%b e=%b want all 0",
                     in_ready, out_valid, result, carryout, overflow, zero, error);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_edge_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        run_op(32'h0000_0001, 32'h0000_0001, 3'b000,
               '{result: 32'h0000_0002, carryout: 1'b0, overflow: 1'b0, zero: 1'b0, error: 1'b0},
               0, "add_1_1");
        run_op(32'h8000_0001, 32'h8000_0001, 3'b000,
               '{result: 32'h0000_0002, carryout: 1'b1, overflow: 1'b1, zero: 1'b0, error: 1'b0},
               0, "add_ovf");
    endtask

    task automatic test_sub();
        run_op(32'h0000_0001, 32'h0000_0001, 3'b001,
               '{result: 32'h0000_0000, carryout: 1'b1, overflow: 1'b0, zero: 1'b1, error: 1'b0},
               0, "sub_zero");
        run_op(32'h0020_0000, 32'h0000_0080, 3'b001,
               '{result: 32'h001F_FF80, carryout: 1'b1, overflow: 1'b0, zero: 1'b0, error: 1'b0},
               0, "sub_borrow_chain");
        run_op(32'h0000_0000, 32'h8000_0001, 3'b001,
               '{result: 32'h7FFF_FFFF, carryout: 1'b0, overflow: 1'b0, zero: 1'b0, error: 1'b0},
               0, "sub_neg");
    endtask

    task automatic test_illegal();
        run_op(32'h0000_0001, 32'h0000_0001, 3'b100,
               '{result: 32'h0000_0000, carryout: 1'b0, overflow: 1'b0, zero: 1'b1, error: 1'b1},
               0, "illegal_100");
        // A legal op right after must clear the error flag.
        run_op(32'h0000_0005, 32'h0000_0003, 3'b001,
               '{result: 32'h0000_0002, carryout: 1'b1, overflow: 1'b0, zero: 1'b0, error: 1'b0},
               0, "after_illegal");
    endtask

    task automatic test_backpressure();
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 3'b000,
               model(32'h1234_5678, 32'h0F0F_0F0F, 3'b000), 6, "backpressure");
        // Requests offered during the stall must not have been taken.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_idle%0d: got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_abort();
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        command  = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Now in the second RUN cycle with a partial result in flight.
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, carryout, overflow, zero, error} !== '0) begin
            failures++;
            $display("FAIL abort_async: got rdy=%b v=%b r=%h c=%b o=%b z=%b e=%b want all 0",
                     in_ready, out_valid, result, carryout, overflow, zero, error);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_valid%0d: got %b want 0", i, out_valid);
            end
        end
        run_op(32'd3, 32'd4, 3'b000,
               '{result: 32'd7, carryout: 1'b0, overflow: 1'b0, zero: 1'b0, error: 1'b0},
               0, "add_3_4");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra, rb;
        logic [2:0]   rc;
        int           r;
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i == 3) ? ra : $urandom;
            r  = $urandom_range(0, 9);
            rc = (r < 4) ? 3'b000 : (r < 8) ? 3'b001 : 3'(r - 6);
            if (i == 3) rc = 3'b001;
            run_op(ra, rb, rc, model(ra, rb, rc), 0, $sformatf("b2b%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_illegal();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
